// File: rtl/tych_ing_pkg.sv
// Shared types and default parameters for the multi-port ingress front end.
package tych_ing_pkg;

   localparam int DEF_NUM_PORTS  = 4;
   localparam int DEF_DATA_W     = 64;
   localparam int DEF_FIFO_DEPTH = 16;
   localparam int DEF_LEN_W      = 16;
   localparam int DEF_EMPTY_W    = $clog2(DEF_DATA_W / 8);
   localparam int DEF_PORT_W     = (DEF_NUM_PORTS > 1) ? $clog2(DEF_NUM_PORTS) : 1;

   // Per-packet metadata as presented with the sop beat.
   typedef struct packed {
      logic [DEF_PORT_W-1:0] port;
      logic [DEF_LEN_W-1:0]  len;
      logic                  error;
   } ing_meta_t;

   typedef enum logic {
      WR_IDLE = 1'b0,
      WR_PKT  = 1'b1
   } wr_state_t;

   typedef enum logic {
      ARB_SEL  = 1'b0,
      ARB_XFER = 1'b1
   } arb_state_t;

   // Drop counters stick at all-ones instead of wrapping.
   function automatic logic [15:0] sat_add16(input logic [15:0] cnt, input logic [1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, cnt} + {15'd0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/tych_ing_mux_if.sv
// MAC RX ports, core AVL output, metadata and drop counters of the ingress mux.
interface tych_ing_mux_if
   import tych_ing_pkg::*;
#(
   parameter int NUM_PORTS = DEF_NUM_PORTS,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int EMPTY_W   = $clog2(DATA_W / 8),
   parameter int LEN_W     = DEF_LEN_W,
   parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
);
   logic [NUM_PORTS-1:0]         rx_valid;
   logic [NUM_PORTS-1:0]         rx_sop;
   logic [NUM_PORTS-1:0]         rx_eop;
   logic [NUM_PORTS*DATA_W-1:0]  rx_data;
   logic [NUM_PORTS*EMPTY_W-1:0] rx_empty;
   logic [NUM_PORTS-1:0]         rx_error;

   logic                         out_valid;
   logic                         out_sop;
   logic                         out_eop;
   logic                         out_error;
   logic [DATA_W-1:0]            out_data;
   logic [EMPTY_W-1:0]           out_empty;
   logic                         out_ready;

   logic                         meta_valid;
   logic [PORT_W-1:0]            meta_port;
   logic [LEN_W-1:0]             meta_len;
   logic                         meta_error;

   logic [NUM_PORTS*16-1:0]      drop_cnt;

   // MAC/core side: drives RX streams and ready.
   modport master (
      output rx_valid, rx_sop, rx_eop, rx_data, rx_empty, rx_error, out_ready,
      input  out_valid, out_sop, out_eop, out_error, out_data, out_empty,
      input  meta_valid, meta_port, meta_len, meta_error, drop_cnt
   );

   // Ingress mux side.
   modport slave (
      input  rx_valid, rx_sop, rx_eop, rx_data, rx_empty, rx_error, out_ready,
      output out_valid, out_sop, out_eop, out_error, out_data, out_empty,
      output meta_valid, meta_port, meta_len, meta_error, drop_cnt
   );
endinterface

// File: rtl/tych_ing_port_fifo.sv
// One ingress port: write FSM, commit/rewind data FIFO, length FIFO, drop counter.
//
// state   | meaning
// WR_IDLE | between packets; non-sop beats are discarded
// WR_PKT  | packet open, beats written speculatively at wr_ptr
module tych_ing_port_fifo
   import tych_ing_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int EMPTY_W    = $clog2(DATA_W / 8),
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int LEN_W      = DEF_LEN_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx_valid,
   input  logic               rx_sop,
   input  logic               rx_eop,
   input  logic [DATA_W-1:0]  rx_data,
   input  logic [EMPTY_W-1:0] rx_empty,
   input  logic               rx_error,
   output logic               pkt_avail,
   output logic [LEN_W-1:0]   head_len,
   output logic               head_err,
   output logic [DATA_W-1:0]  rd_data,
   output logic [EMPTY_W-1:0] rd_empty,
   output logic               rd_eop,
   input  logic               rd_pop,
   input  logic               len_pop,
   output logic [15:0]        drop_cnt
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int BYTES = DATA_W / 8;
   localparam logic [PTR_W:0] PTR_ONE = 1;

   wr_state_t state, state_nxt;

   logic [PTR_W:0]   wr_ptr, cmt_ptr, rd_ptr, lw_ptr, lr_ptr;
   logic [LEN_W-1:0] byte_cnt;

   logic [DATA_W-1:0]  dmem [FIFO_DEPTH];
   logic [EMPTY_W-1:0] emem [FIFO_DEPTH];
   logic               eomem[FIFO_DEPTH];
   logic [LEN_W:0]     lmem [FIFO_DEPTH];

   logic             take, abort, ovf, wr_en, commit, d_full, l_full;
   logic [PTR_W:0]   base_ptr;
   logic [LEN_W-1:0] base_cnt, beat_len;
   logic [1:0]       drop_inc;

   assign l_full    = (lw_ptr[PTR_W] != lr_ptr[PTR_W]) &&
                      (lw_ptr[PTR_W-1:0] == lr_ptr[PTR_W-1:0]);
   assign pkt_avail = (lw_ptr != lr_ptr);
   assign {head_len, head_err} = lmem[lr_ptr[PTR_W-1:0]];
   assign rd_data   = dmem[rd_ptr[PTR_W-1:0]];
   assign rd_empty  = emem[rd_ptr[PTR_W-1:0]];
   assign rd_eop    = eomem[rd_ptr[PTR_W-1:0]];

   // Write FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= WR_IDLE;
      else     state <= state_nxt;
   end

   // Next state: any accepted beat either keeps the packet open or closes it.
   always_comb begin
      state_nxt = state;
      if (take) state_nxt = (wr_en && !rx_eop) ? WR_PKT : WR_IDLE;
   end

   // Write-side control: an aborting sop restarts from the commit pointer.
   always_comb begin
      take     = rx_valid && (state == WR_PKT || rx_sop);
      abort    = rx_valid && rx_sop && (state == WR_PKT);
      base_ptr = abort ? cmt_ptr : wr_ptr;
      base_cnt = rx_sop ? '0 : byte_cnt;
      d_full   = (base_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (base_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
      ovf      = take && (d_full || (rx_eop && l_full));
      wr_en    = take && !ovf;
      commit   = wr_en && rx_eop;
      beat_len = base_cnt + LEN_W'(BYTES) - (rx_eop ? LEN_W'(rx_empty) : '0);
      drop_inc = {1'b0, abort} + {1'b0, ovf};
   end

   // Pointers, byte count and drop counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         cmt_ptr  <= '0;
         rd_ptr   <= '0;
         lw_ptr   <= '0;
         lr_ptr   <= '0;
         byte_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (ovf)        wr_ptr <= cmt_ptr;
         else if (wr_en) wr_ptr <= base_ptr + PTR_ONE;
         if (commit) begin
            cmt_ptr <= base_ptr + PTR_ONE;
            lw_ptr  <= lw_ptr + PTR_ONE;
         end
         if (wr_en)   byte_cnt <= beat_len;
         if (rd_pop)  rd_ptr   <= rd_ptr + PTR_ONE;
         if (len_pop) lr_ptr   <= lr_ptr + PTR_ONE;
         drop_cnt <= sat_add16(drop_cnt, drop_inc);
      end
   end

   // Storage arrays; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         dmem[base_ptr[PTR_W-1:0]]  <= rx_data;
         emem[base_ptr[PTR_W-1:0]]  <= rx_eop ? rx_empty : '0;
         eomem[base_ptr[PTR_W-1:0]] <= rx_eop;
      end
      if (commit) lmem[lw_ptr[PTR_W-1:0]] <= {beat_len, rx_error};
   end
endmodule

// File: rtl/tych_ing_mux.sv
// Ingress front end top: per-port FIFOs, whole-packet round-robin arbiter, output register.
//
// state    | meaning
// ARB_SEL  | output idle, pick next eligible port and load its sop beat
// ARB_XFER | grant locked, stream beats until the eop beat is accepted
module tych_ing_mux
   import tych_ing_pkg::*;
#(
   parameter int NUM_PORTS  = DEF_NUM_PORTS,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int EMPTY_W    = $clog2(DATA_W / 8),
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int LEN_W      = DEF_LEN_W,
   parameter int PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input logic           clk,
   input logic           rst,
   tych_ing_mux_if.slave bus
);
   logic [NUM_PORTS-1:0] pkt_avail, rd_pop, len_pop, rd_eop, head_err;
   logic [LEN_W-1:0]     head_len [NUM_PORTS];
   logic [DATA_W-1:0]    rd_data  [NUM_PORTS];
   logic [EMPTY_W-1:0]   rd_empty [NUM_PORTS];
   logic [NUM_PORTS*16-1:0] drop_cnt;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      tych_ing_port_fifo #(
         .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
      ) u_fifo (
         .clk      (clk),
         .rst      (rst),
         .rx_valid (bus.rx_valid[p]),
         .rx_sop   (bus.rx_sop[p]),
         .rx_eop   (bus.rx_eop[p]),
         .rx_data  (bus.rx_data[p*DATA_W +: DATA_W]),
         .rx_empty (bus.rx_empty[p*EMPTY_W +: EMPTY_W]),
         .rx_error (bus.rx_error[p]),
         .pkt_avail(pkt_avail[p]),
         .head_len (head_len[p]),
         .head_err (head_err[p]),
         .rd_data  (rd_data[p]),
         .rd_empty (rd_empty[p]),
         .rd_eop   (rd_eop[p]),
         .rd_pop   (rd_pop[p]),
         .len_pop  (len_pop[p]),
         .drop_cnt (drop_cnt[p*16 +: 16])
      );
   end

   arb_state_t state, state_nxt;

   logic [PORT_W-1:0]  rr_ptr, gnt_port, arb_pick, sel;
   logic               any_avail, grant, load, accept;
   logic               out_valid_q, out_sop_q, out_eop_q, out_error_q;
   logic [DATA_W-1:0]  out_data_q;
   logic [EMPTY_W-1:0] out_empty_q;
   logic [LEN_W-1:0]   meta_len_q;
   logic               meta_error_q;

   function automatic logic [PORT_W-1:0] rr_idx(input logic [PORT_W-1:0] base, input int off);
      int c;
      c = int'(base) + off;
      if (c >= NUM_PORTS) c = c - NUM_PORTS;
      return PORT_W'(c);
   endfunction

   assign accept = out_valid_q && bus.out_ready;

   // Round-robin search from rr_ptr; scanning backwards lets the closest port win.
   always_comb begin
      any_avail = 1'b0;
      arb_pick  = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (pkt_avail[rr_idx(rr_ptr, i)]) begin
            any_avail = 1'b1;
            arb_pick  = rr_idx(rr_ptr, i);
         end
      end
   end

   // Arbiter state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ARB_SEL;
      else     state <= state_nxt;
   end

   // Grant locks from selection until the eop beat is accepted.
   always_comb begin
      state_nxt = state;
      case (state)
         ARB_SEL:  if (any_avail) state_nxt = ARB_XFER;
         ARB_XFER: if (accept && out_eop_q) state_nxt = ARB_SEL;
         default:  state_nxt = ARB_SEL;
      endcase
   end

   // Load the output register whenever it frees up and the packet has beats left.
   always_comb begin
      grant   = (state == ARB_SEL) && any_avail;
      load    = grant || ((state == ARB_XFER) && (!out_valid_q || bus.out_ready) &&
                          !(out_valid_q && out_eop_q));
      sel     = grant ? arb_pick : gnt_port;
      rd_pop  = '0;
      len_pop = '0;
      if (load) rd_pop[sel] = 1'b1;
      if (accept && out_sop_q) len_pop[gnt_port] = 1'b1;
   end

   // AVL output register; holds everything while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_error_q <= 1'b0;
         out_data_q  <= '0;
         out_empty_q <= '0;
      end else if (load) begin
         out_valid_q <= 1'b1;
         out_sop_q   <= grant;
         out_eop_q   <= rd_eop[sel];
         out_data_q  <= rd_data[sel];
         out_empty_q <= rd_eop[sel] ? rd_empty[sel] : '0;
         out_error_q <= rd_eop[sel] && (grant ? head_err[sel] : meta_error_q);
      end else if (accept) begin
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_error_q <= 1'b0;
      end
   end

   // Grant, round-robin pointer and per-packet metadata captured at selection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_port     <= '0;
         rr_ptr       <= '0;
         meta_len_q   <= '0;
         meta_error_q <= 1'b0;
      end else if (grant) begin
         gnt_port     <= arb_pick;
         rr_ptr       <= rr_idx(arb_pick, 1);
         meta_len_q   <= head_len[arb_pick];
         meta_error_q <= head_err[arb_pick];
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_sop    = out_sop_q;
   assign bus.out_eop    = out_eop_q;
   assign bus.out_error  = out_error_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_empty  = out_empty_q;
   assign bus.meta_valid = out_valid_q && out_sop_q;
   assign bus.meta_port  = gnt_port;
   assign bus.meta_len   = meta_len_q;
   assign bus.meta_error = meta_error_q;
   assign bus.drop_cnt   = drop_cnt;
endmodule
